// File: rtl/ddc_iq_ser_pkg.sv
// ---------------------------------------------------------------------------
// ddc_iq_ser_pkg
// Shared constants and types for the I/Q serializer slice.
//   DSZ_DEF    : default I/Q sample width
//   ASZ_DEF    : default FIFO address width (depth = 2**ASZ_DEF pairs)
//   CLKDIV_DEF : default clk cycles per sclk half-period
//   FRAME_LEN  : serial frame length for the default sample width
//   ser_state_e: serializer FSM state encoding
// ---------------------------------------------------------------------------
package ddc_iq_ser_pkg;

    localparam int DSZ_DEF    = 16;
    localparam int ASZ_DEF    = 2;
    localparam int CLKDIV_DEF = 4;
    localparam int FRAME_LEN  = 2 * DSZ_DEF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/ddc_iq_ser_if.sv
// ---------------------------------------------------------------------------
// ddc_iq_ser_if
// Groups the sample-stream input and the serial/status outputs of ddc_iq_ser.
//   valid, i_in, q_in : I/Q pair strobe and samples (from the downconverter)
//   ovf_clr           : clear of the sticky overflow flag
//   sclk, sync, sdat  : serial bit clock, frame sync, serial data
//   ovf, level        : sticky overflow flag, FIFO occupancy
// master = sample source / serial receiver side, slave = the serializer.
// ---------------------------------------------------------------------------
interface ddc_iq_ser_if
    import ddc_iq_ser_pkg::*;
#(
    parameter int dsz = DSZ_DEF,
    parameter int asz = ASZ_DEF
);
    logic                  valid;
    logic signed [dsz-1:0] i_in;
    logic signed [dsz-1:0] q_in;
    logic                  ovf_clr;
    logic                  sclk;
    logic                  sync;
    logic                  sdat;
    logic                  ovf;
    logic [asz:0]          level;

    modport master (
        output valid, i_in, q_in, ovf_clr,
        input  sclk, sync, sdat, ovf, level
    );

    modport slave (
        input  valid, i_in, q_in, ovf_clr,
        output sclk, sync, sdat, ovf, level
    );
endinterface

// File: rtl/ddc_iq_ser_iq_fifo.sv
// ---------------------------------------------------------------------------
// iq_fifo
// Synchronous first-word-fall-through FIFO holding packed {I,Q} words.
//   clk, reset : clock, asynchronous active-low reset
//   wr, wdat   : write request and data
//   rd, rdat   : pop request and head word (valid whenever !empty)
//   level      : registered occupancy 0..2**ASZ
//   full/empty : occupancy flags
// A write while full is accepted only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module iq_fifo
    import ddc_iq_ser_pkg::*;
#(
    parameter int WIDTH = FRAME_LEN,
    parameter int ASZ   = ASZ_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdat,
    input  logic             rd,
    output logic [WIDTH-1:0] rdat,
    output logic [ASZ:0]     level,
    output logic             full,
    output logic             empty
);
    localparam int            DEPTH   = 1 << ASZ;
    localparam logic [ASZ:0]  DEPTH_L = (ASZ + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ASZ-1:0]   r_wptr;
    logic [ASZ-1:0]   r_rptr;
    logic [ASZ:0]     r_level;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_level == (ASZ + 1)'(0));
    assign full    = (r_level == DEPTH_L);
    assign w_do_rd = rd && !empty;
    assign w_do_wr = wr && (!full || w_do_rd);
    assign rdat    = r_mem[r_rptr];
    assign level   = r_level;

    // Storage array write port; contents need no reset because level gates reads.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr] <= wdat;
        end
    end

    // Pointers (wrap naturally at 2**ASZ) and occupancy counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= ASZ'(0);
            r_rptr  <= ASZ'(0);
            r_level <= (ASZ + 1)'(0);
        end else begin
            if (w_do_wr) begin
                r_wptr <= r_wptr + ASZ'(1);
            end
            if (w_do_rd) begin
                r_rptr <= r_rptr + ASZ'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + (ASZ + 1)'(1);
                2'b01:   r_level <= r_level - (ASZ + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ddc_iq_ser.sv
// ---------------------------------------------------------------------------
// ddc_iq_ser
// Buffers I/Q pairs from the downconverter and shifts each one out MSB-first
// (I then Q) as a 2*dsz-bit frame on a free-running sclk, with a one-bit-time
// frame sync, toward the host serial port.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : slave side of ddc_iq_ser_if (valid/i_in/q_in/ovf_clr in,
//           sclk/sync/sdat/ovf/level out, all outputs registered)
// sdat/sync only move on the clk edge that drops sclk, so the receiver
// samples a stable bit on every sclk rising edge.
// ---------------------------------------------------------------------------
module ddc_iq_ser
    import ddc_iq_ser_pkg::*;
#(
    parameter int dsz    = DSZ_DEF,
    parameter int asz    = ASZ_DEF,
    parameter int clkdiv = CLKDIV_DEF
) (
    input  logic        clk,
    input  logic        reset,
    ddc_iq_ser_if.slave bus
);
    localparam int FLEN = 2 * dsz;
    localparam int BCW  = $clog2(FLEN);
    localparam int DVW  = (clkdiv > 1) ? $clog2(clkdiv) : 1;
    localparam logic [DVW-1:0] DIV_TC   = DVW'(clkdiv - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(FLEN - 1);

    logic [DVW-1:0]  r_div;
    logic            r_sclk;
    ser_state_e      r_state;
    logic [FLEN-2:0] r_shreg;   // bits still to send; MSB already on sdat
    logic [BCW-1:0]  r_bitcnt;
    logic            r_sdat;
    logic            r_sync;
    logic            r_ovf;

    logic            w_tc;
    logic            w_fall;
    logic            w_frame_end;
    logic            w_pop;
    logic            w_drop;
    logic [FLEN-1:0] w_rdat;
    logic [asz:0]    w_level;
    logic            w_full;
    logic            w_empty;

    assign w_tc        = (r_div == DIV_TC);
    assign w_fall      = w_tc && r_sclk;
    assign w_frame_end = (r_state == ST_SHIFT) && (r_bitcnt == BCW'(0));
    // A new frame is loaded on a fall either from idle or right after the
    // last bit of the previous frame, giving back-to-back frames.
    assign w_pop       = w_fall && !w_empty && ((r_state == ST_IDLE) || w_frame_end);
    assign w_drop      = bus.valid && w_full && !w_pop;

    iq_fifo #(
        .WIDTH (FLEN),
        .ASZ   (asz)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (bus.valid),
        .wdat  ({bus.i_in, bus.q_in}),
        .rd    (w_pop),
        .rdat  (w_rdat),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign bus.sclk  = r_sclk;
    assign bus.sync  = r_sync;
    assign bus.sdat  = r_sdat;
    assign bus.ovf   = r_ovf;
    assign bus.level = w_level;

    // Free-running divider producing the 50% duty sclk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div  <= DVW'(0);
            r_sclk <= 1'b0;
        end else if (w_tc) begin
            r_div  <= DVW'(0);
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + DVW'(1);
        end
    end

    // Serializer FSM with shift register and registered sdat/sync.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_shreg  <= (FLEN - 1)'(0);
            r_bitcnt <= BCW'(0);
            r_sdat   <= 1'b0;
            r_sync   <= 1'b0;
        end else if (w_fall) begin
            if (w_pop) begin
                r_state  <= ST_SHIFT;
                r_shreg  <= w_rdat[FLEN-2:0];
                r_sdat   <= w_rdat[FLEN-1];
                r_sync   <= 1'b1;
                r_bitcnt <= BIT_LAST;
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        r_sync <= 1'b0;
                        if (w_frame_end) begin
                            r_state <= ST_IDLE;
                            r_sdat  <= 1'b0;
                        end else begin
                            r_sdat   <= r_shreg[FLEN-2];
                            r_shreg  <= {r_shreg[FLEN-3:0], 1'b0};
                            r_bitcnt <= r_bitcnt - BCW'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_sdat  <= 1'b0;
                        r_sync  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

endmodule

// File: tb/tb_ddc_iq_ser.sv
// ---------------------------------------------------------------------------
// tb_ddc_iq_ser
// Two instances: A (dsz=16, asz=2, clkdiv=4) runs the directed scenarios,
// B (dsz=16, asz=3, clkdiv=2) takes a 100-pair random stream. A behavioural
// model (cycle counter since reset, queue of stored pairs, current frame
// word) predicts sclk/sync/sdat/ovf/level each cycle for both instances.
// ---------------------------------------------------------------------------
module tb_ddc_iq_ser;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddc_iq_ser_if #(.dsz(16), .asz(2)) bus_a ();
    ddc_iq_ser_if #(.dsz(16), .asz(3)) bus_b ();

    ddc_iq_ser #(.dsz(16), .asz(2), .clkdiv(4)) dut_a (.clk(clk), .reset(rst_n), .bus(bus_a));
    ddc_iq_ser #(.dsz(16), .asz(3), .clkdiv(2)) dut_b (.clk(clk), .reset(rst_n), .bus(bus_b));

    int n_cmp = 0;
    int n_mis = 0;

    localparam int CD    [2] = '{4, 2};
    localparam int DEPTH [2] = '{4, 8};

    int unsigned m_n     [2];
    int unsigned m_start [2];
    bit          m_busy  [2];
    bit          m_sync  [2];
    bit          m_sdat  [2];
    bit          m_ovf   [2];
    logic [31:0] m_cur   [2];
    logic [31:0] m_fifo  [2][$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk edge of the reference: fall events every 2*CD edges after reset,
    // a frame lasts 32 bit times, a pair is stored if room or a frame starts.
    task automatic model_step(input int d, input bit v, input logic [31:0] w, input bit clr);
        int unsigned n;
        int          p0;
        int          idx;
        bit          pop;
        bit          at_end;
        n      = m_n[d] + 1;
        m_n[d] = n;
        p0     = m_fifo[d].size();
        pop    = 1'b0;
        if (n % (2 * CD[d]) == 0) begin
            at_end = m_busy[d] && (n == m_start[d] + 64 * CD[d]);
            if ((!m_busy[d] || at_end) && p0 > 0) begin
                pop        = 1'b1;
                m_cur[d]   = m_fifo[d].pop_front();
                m_start[d] = n;
                m_busy[d]  = 1'b1;
                m_sdat[d]  = m_cur[d][31];
                m_sync[d]  = 1'b1;
            end else if (m_busy[d] && !at_end) begin
                idx       = int'((n - m_start[d]) / (2 * CD[d]));
                m_sdat[d] = m_cur[d][31 - idx];
                m_sync[d] = 1'b0;
            end else begin
                m_busy[d] = 1'b0;
                m_sdat[d] = 1'b0;
                m_sync[d] = 1'b0;
            end
        end
        if (v && (p0 < DEPTH[d] || pop)) begin
            m_fifo[d].push_back(w);
        end
        if (v && !(p0 < DEPTH[d] || pop)) begin
            m_ovf[d] = 1'b1;
        end else if (clr) begin
            m_ovf[d] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_n[d] = 0; m_start[d] = 0; m_busy[d] = 1'b0;
                m_sync[d] = 1'b0; m_sdat[d] = 1'b0; m_ovf[d] = 1'b0;
                m_cur[d] = 32'h0;
                m_fifo[d].delete();
            end
        end else begin
            model_step(0, bus_a.valid, {bus_a.i_in, bus_a.q_in}, bus_a.ovf_clr);
            model_step(1, bus_b.valid, {bus_b.i_in, bus_b.q_in}, bus_b.ovf_clr);
        end
    end

    task automatic mon(input int d, input logic sclk, input logic sync, input logic sdat,
                       input logic ovf, input logic [3:0] level);
        string p;
        p = (d == 0) ? "a" : "b";
        chk({p, "_sclk"},  sclk,  ((m_n[d] / CD[d]) % 2));
        chk({p, "_sync"},  sync,  m_sync[d]);
        chk({p, "_sdat"},  sdat,  m_sdat[d]);
        chk({p, "_ovf"},   ovf,   m_ovf[d]);
        chk({p, "_level"}, level, m_fifo[d].size());
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, bus_a.sclk, bus_a.sync, bus_a.sdat, bus_a.ovf, {1'b0, bus_a.level});
            mon(1, bus_b.sclk, bus_b.sync, bus_b.sdat, bus_b.ovf, bus_b.level);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] word;
        logic [95:0] bits;
        int lat, hi, nb, ns, maxl;
        int st [3];
        bit pv_sclk, pv_sync, coll;

        bus_a.valid = 1'b0; bus_a.i_in = 16'h0; bus_a.q_in = 16'h0; bus_a.ovf_clr = 1'b0;
        bus_b.valid = 1'b0; bus_b.i_in = 16'h0; bus_b.q_in = 16'h0; bus_b.ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk",  bus_a.sclk,  1'b0);
        chk("rst_sync",  bus_a.sync,  1'b0);
        chk("rst_sdat",  bus_a.sdat,  1'b0);
        chk("rst_ovf",   bus_a.ovf,   1'b0);
        chk("rst_level", bus_a.level, 3'd0);
        chk("rst_level_b", bus_b.level, 4'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: single pair, latency, sync width, bit order, return to idle
        bus_a.valid = 1'b1; bus_a.i_in = 16'h8001; bus_a.q_in = 16'h7FFE;
        @(negedge clk);
        bus_a.valid = 1'b0;
        lat = 1;
        while (!bus_a.sync && lat < 20) begin @(negedge clk); lat++; end
        chk("t1_sync_latency_le9", (lat <= 9), 1'b1);
        word = 32'h0; nb = 0; hi = 0; pv_sclk = bus_a.sclk;
        for (int c = 0; c < 260; c++) begin
            if (bus_a.sync) hi++;
            if (bus_a.sclk && !pv_sclk && nb < 32) begin word = {word[30:0], bus_a.sdat}; nb++; end
            pv_sclk = bus_a.sclk;
            @(negedge clk);
        end
        chk("t1_sync_width", hi, 8);
        chk("t1_frame", word, 32'h80017FFE);
        chk("t1_sdat_idle", bus_a.sdat, 1'b0);
        chk("t1_level_idle", bus_a.level, 3'd0);

        // 2: three pairs 10 clk apart -> three contiguous frames
        ns = 0; nb = 0; maxl = 0; bits = 96'h0; coll = 1'b0;
        pv_sclk = bus_a.sclk; pv_sync = bus_a.sync;
        for (int c = 0; c < 900; c++) begin
            if (c == 0 || c == 10 || c == 20) begin
                bus_a.valid = 1'b1;
                bus_a.i_in  = 16'(2 * (c / 10) + 1);
                bus_a.q_in  = 16'(2 * (c / 10) + 2);
            end else begin
                bus_a.valid = 1'b0;
            end
            @(negedge clk);
            if (bus_a.sync && !pv_sync) begin
                if (ns < 3) st[ns] = c;
                ns++;
                coll = 1'b1;
            end
            if (coll && bus_a.sclk && !pv_sclk && nb < 96) begin bits = {bits[94:0], bus_a.sdat}; nb++; end
            if (int'(bus_a.level) > maxl) maxl = int'(bus_a.level);
            pv_sclk = bus_a.sclk; pv_sync = bus_a.sync;
        end
        chk("t2_sync_count", ns, 3);
        chk("t2_gap_1_2", st[1] - st[0], 256);
        chk("t2_gap_2_3", st[2] - st[1], 256);
        chk("t2_frames", bits, {32'h00010002, 32'h00030004, 32'h00050006});
        chk("t2_level_peak", maxl, 2);
        chk("t2_level_end", bus_a.level, 3'd0);

        // 3: overflow burst, clear, drop coincident with clear
        for (int c = 0; c < 6; c++) begin
            bus_a.valid = 1'b1; bus_a.i_in = 16'($urandom); bus_a.q_in = 16'($urandom);
            @(negedge clk);
        end
        bus_a.valid = 1'b0;
        chk("t3_level_full", bus_a.level, 3'd4);
        chk("t3_ovf_set", bus_a.ovf, 1'b1);
        repeat (12) @(negedge clk);
        bus_a.ovf_clr = 1'b1;
        @(negedge clk);
        bus_a.ovf_clr = 1'b0;
        chk("t3_ovf_cleared", bus_a.ovf, 1'b0);
        bus_a.valid = 1'b1; bus_a.i_in = 16'($urandom); bus_a.q_in = 16'($urandom);
        @(negedge clk);
        bus_a.ovf_clr = 1'b1; bus_a.i_in = 16'($urandom); bus_a.q_in = 16'($urandom);
        @(negedge clk);
        bus_a.valid = 1'b0; bus_a.ovf_clr = 1'b0;
        chk("t3_set_wins", bus_a.ovf, 1'b1);
        chk("t3_level_still_full", bus_a.level, 3'd4);

        // 4: write on the exact cycle of a pop while full
        bus_a.ovf_clr = 1'b1;
        @(negedge clk);
        bus_a.ovf_clr = 1'b0;
        chk("t4_ovf_pre", bus_a.ovf, 1'b0);
        lat = 0;
        while (!(m_busy[0] && (m_n[0] + 1 == m_start[0] + 64 * CD[0])) && lat < 400) begin
            @(negedge clk); lat++;
        end
        chk("t4_full_before", bus_a.level, 3'd4);
        bus_a.valid = 1'b1; bus_a.i_in = 16'hA5A5; bus_a.q_in = 16'h5A5A;
        @(negedge clk);
        bus_a.valid = 1'b0;
        chk("t4_level_stays", bus_a.level, 3'd4);
        chk("t4_ovf_clear", bus_a.ovf, 1'b0);
        chk("t4_new_frame", bus_a.sync, 1'b1);

        // 5: reset at bit 10 of a frame with level 2
        lat = 0;
        while (bus_a.level != 3'd2 && lat < 1200) begin @(negedge clk); lat++; end
        while (((m_n[0] - m_start[0]) / (2 * CD[0])) != 10 && lat < 1400) begin @(negedge clk); lat++; end
        chk("t5_level_pre", bus_a.level, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_sclk",  bus_a.sclk,  1'b0);
        chk("t5_rst_sync",  bus_a.sync,  1'b0);
        chk("t5_rst_sdat",  bus_a.sdat,  1'b0);
        chk("t5_rst_ovf",   bus_a.ovf,   1'b0);
        chk("t5_rst_level", bus_a.level, 3'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        ns = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus_a.sync) ns++;
        end
        chk("t5_no_frame", ns, 0);
        chk("t5_level_after", bus_a.level, 3'd0);

        // 6: instance B, 100 random pairs at one per frame time (128 clk)
        ns = 0; pv_sync = bus_b.sync;
        for (int k = 0; k < 100; k++) begin
            for (int c = 0; c < 128; c++) begin
                bus_b.valid = (c == 0);
                if (c == 0) begin bus_b.i_in = 16'($urandom); bus_b.q_in = 16'($urandom); end
                @(negedge clk);
                if (bus_b.sync && !pv_sync) ns++;
                pv_sync = bus_b.sync;
            end
        end
        bus_b.valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus_b.sync && !pv_sync) ns++;
            pv_sync = bus_b.sync;
        end
        chk("t6_frames", ns, 100);
        chk("t6_ovf", bus_b.ovf, 1'b0);
        chk("t6_level_end", bus_b.level, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ddc_iq_ser.md
Name: ddc_iq_ser

Overview:
- Sits directly downstream of the decimating downconverter and consumes its `valid` / `i_out` / `q_out` stream (one I/Q pair per `valid` pulse, about 19.5 kHz at 40 MHz `clk`).
- Buffers I/Q pairs in a small FIFO.
- Shifts each pair out MSB-first as a 2×dsz-bit serial frame on a free-running bit clock, with a frame-sync pulse, toward the host MCU serial port.
- Flags FIFO overflow.

Parameters:
- dsz, 16, width of I and Q samples; frame length = 2*dsz bits.
- asz, 2, FIFO address bits; depth = 2**asz pairs.
- clkdiv, 4, `clk` cycles per `sclk` half-period; legal range ≥ 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- valid  in  1  one-cycle strobe: new I/Q pair present.
- i_in  in  dsz  signed I sample, qualified by `valid`.
- q_in  in  dsz  signed Q sample, qualified by `valid`.
- ovf_clr  in  1  synchronous clear of the sticky overflow flag.
- sclk  out  1  serial bit clock, 50% duty, period 2*clkdiv `clk`.
- sync  out  1  high for exactly the first bit time of each frame.
- sdat  out  1  serial data; changes on `sclk` falling edge; receiver samples on rising edge.
- ovf  out  1  sticky: a pair was dropped because the FIFO was full.
- level  out  asz+1  current FIFO occupancy, 0..2**asz.

Behaviour:
- Reset (reset=0, asynchronous): sclk=0, sync=0, sdat=0, ovf=0, level=0, divider=0, state=IDLE, FIFO pointers=0. All outputs are registered.
- Divider: counter 0..clkdiv-1. At terminal count it wraps and `sclk` toggles.
  - "fall" event = terminal count while sclk=1.
  - "rise" event = terminal count while sclk=0.
  - `sclk` runs continuously, including while idle.
- FIFO write: on `valid`, the word {i_in,q_in} is written when level < depth, or when level == depth and a pop occurs in the same cycle (level then unchanged).
  - Otherwise the pair is dropped and ovf=1 on the next edge.
  - ovf_clr=1 clears ovf. If a drop and ovf_clr coincide, ovf=1 (set wins).
- Serializer FSM, states IDLE, SHIFT:
  - IDLE: on a fall event with level > 0:
    - pop the head word into the 2*dsz shift register;
    - sdat = bit[2*dsz-1] (I MSB), sync=1;
    - bit counter = 2*dsz-1; go to SHIFT.
  - IDLE with FIFO empty: sdat=0, sync=0.
  - SHIFT: on each fall event, shift left one bit, sdat = new MSB, sync=0, decrement bit counter.
  - SHIFT, fall event with bit counter = 0 (last bit already on the line):
    - if level > 0, pop and load the next frame back-to-back (sync=1, no gap bit);
    - else sdat=0, go to IDLE.
- Bit order per frame: I[dsz-1]..I[0], Q[dsz-1]..Q[0].
- `sync` and `sdat` change only on the `clk` edge that produces an `sclk` fall.
- Latency: `valid` into an empty FIFO with the FSM idle → `sync` rises within 2*clkdiv+1 `clk` cycles.
- `level` reflects writes and pops with one-cycle registered latency. The `level` > 0 check uses the registered value.
- Pointers wrap modulo depth.
- `valid` while the FIFO is full and no pop is due → pair dropped; FIFO contents unchanged.
- Reset asserted mid-frame: frame is abandoned immediately and all buffered pairs are discarded.
- ovf_clr has no effect on data flow.

Decomposition:
- Shared package holds:
  - FRAME_LEN = 2*dsz;
  - FSM state encodings ST_IDLE and ST_SHIFT;
  - the default clkdiv.
- One natural sub-module, `iq_fifo`: synchronous FIFO, width 2*dsz, depth 2**asz.
  - Ports: wr, wdat, rd, rdat (first-word-fall-through), level, full, empty.
  - Uses the same async active-low reset.
- Divider, FSM and shift register stay in `ddc_iq_ser`.

Test Plan:
1. Reset release, then one `valid` with i_in=16'h8001, q_in=16'h7FFE (clkdiv=4):
   - `sync` high for 8 clk starting ≤9 clk after `valid`;
   - sampled rising-edge bits = 32'h80017FFE;
   - `sdat` returns to 0 and FSM to IDLE after 256 clk.
2. Back-to-back frames: 3 `valid`s spaced 10 clk, pairs (1,2), (3,4), (5,6):
   - three contiguous 32-bit frames with no idle bit between;
   - `sync` once per frame;
   - `level` peaks at 2 and ends at 0.
3. Overflow: 6 `valid`s on consecutive cycles with depth 4, FSM idle:
   - 4 pairs stored (first popped at next fall, so ≤5 accepted depending on phase; check against model);
   - ovf=1;
   - ovf_clr pulse → ovf=0;
   - drop coincident with ovf_clr → ovf stays 1.
4. Full + pop same cycle: fill to level 4, drive `valid` on the exact cycle of a pop:
   - pair accepted, level stays 4, ovf=0.
5. Reset mid-frame at bit 10 of a frame with level 2:
   - all outputs 0 immediately (async);
   - after release, no frame until a new `valid`.
6. clkdiv=2 and asz=3 parameterisation: random 100-pair stream at the max rate the serializer sustains:
   - scoreboard matches every pair in order;
   - ovf stays 0.
